// File: rtl/mpu_6050_seq.sv
// mpu_6050_seq: bring-up and periodic measurement sequencer driving top_mpu_6050.
// Define MPU_SEQ_FIFO_EN to switch the measurement script to FIFO reads.
module mpu_6050_seq #(
    parameter int          FPGA_CLK  = 50_000_000,
    parameter int          SAMPLE_HZ = 1_000,
    parameter int          INSTR_SZ  = 8,
    parameter logic [7:0]  CFG_INSTR = 8'h12,
    parameter logic [7:0]  WHO_VAL   = 8'h68,
    parameter int          MAX_RETRY = 3,
    parameter int          ACC_TO    = 1024
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                I_START,
    input  logic                I_STOP,
    input  logic                I_BUSY,
    input  logic                I_ACK_FL,
    input  logic [7:0]          I_RD_DATA,
    output logic                O_EN,
    output logic [INSTR_SZ-1:0] O_INSTR,
    output logic                O_RUN,
    output logic                O_SMP_STB,
    output logic                O_OVR,
    output logic                O_FAULT,
    output logic [3:0]          O_RETRY_CNT
);
    localparam int PERIOD_CYC = FPGA_CLK / SAMPLE_HZ;
    localparam int PW = $clog2(PERIOD_CYC + 1);
    localparam int AW = $clog2(ACC_TO + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);
`ifdef MPU_SEQ_FIFO_EN
    localparam logic       HAS_FIFO   = 1'b1;
    localparam logic [2:0] LAST_BRING = 3'd3;
    localparam logic [2:0] FIRST_MSR  = 3'd4;
    localparam logic [2:0] LAST_MSR   = 3'd4;
    localparam logic [2:0] STOP_STEP  = 3'd5;
`else
    localparam logic       HAS_FIFO   = 1'b0;
    localparam logic [2:0] LAST_BRING = 3'd1;
    localparam logic [2:0] FIRST_MSR  = 3'd2;
    localparam logic [2:0] LAST_MSR   = 3'd4;
    localparam logic [2:0] STOP_STEP  = 3'd7;
`endif

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACC, WAIT_DONE, EVAL, WAIT_TICK, FAULT} state_t;

    state_t              state_q, state_d;
    logic [2:0]          step_q, step_d;
    logic [RW-1:0]       rtry_q, rtry_d;
    logic [3:0]          tot_q, tot_d;
    logic [AW-1:0]       acc_q, acc_d;
    logic [PW-1:0]       cnt_q, cnt_d;
    logic [INSTR_SZ-1:0] instr_q, instr_d;
    logic                err_q, err_d, run_q, run_d, stb_q, stb_d, ovr_q, ovr_d, fault_q, fault_d;
    logic                tick, ev_err;

    function automatic logic [INSTR_SZ-1:0] rom(input logic [2:0] s);
`ifdef MPU_SEQ_FIFO_EN
        case (s)
            3'd0:    rom = INSTR_SZ'(8'h0F);
            3'd1:    rom = INSTR_SZ'(CFG_INSTR);
            3'd2:    rom = INSTR_SZ'(8'h67);
            3'd3:    rom = INSTR_SZ'(8'hBC);
            3'd4:    rom = INSTR_SZ'(8'h0E);
            default: rom = INSTR_SZ'(8'hDC);
        endcase
`else
        case (s)
            3'd0:    rom = INSTR_SZ'(8'h0F);
            3'd1:    rom = INSTR_SZ'(CFG_INSTR);
            3'd2:    rom = INSTR_SZ'(8'h08);
            3'd3:    rom = INSTR_SZ'(8'h09);
            default: rom = INSTR_SZ'(8'h0A);
        endcase
`endif
    endfunction

    assign tick   = run_q && (cnt_q == PW'(PERIOD_CYC - 1));
    // WHO_AM_I mismatch is folded into the error path so it gets retried
    assign ev_err = err_q || (step_q == 3'd0 && I_RD_DATA != WHO_VAL);

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        rtry_d  = rtry_q;
        tot_d   = tot_q;
        acc_d   = acc_q;
        instr_d = instr_q;
        err_d   = err_q;
        run_d   = run_q;
        stb_d   = 1'b0;
        fault_d = fault_q;
        cnt_d   = run_q ? (tick ? '0 : cnt_q + 1'b1) : '0;
        ovr_d   = ovr_q | (tick && state_q != WAIT_TICK);
        case (state_q)
            IDLE: if (I_START && !I_STOP) begin
                state_d = ISSUE;
                step_d  = 3'd0;
                rtry_d  = '0;
            end
            ISSUE: begin
                instr_d = rom(step_q);
                acc_d   = '0;
                err_d   = 1'b0;
                state_d = WAIT_ACC;
            end
            WAIT_ACC: if (I_BUSY) begin
                state_d = WAIT_DONE;
            end else if (acc_q == AW'(ACC_TO - 1)) begin
                err_d   = 1'b1;
                state_d = EVAL;
            end else begin
                acc_d = acc_q + 1'b1;
            end
            WAIT_DONE: if (!I_BUSY) begin
                err_d   = I_ACK_FL;
                state_d = EVAL;
            end
            EVAL: if (ev_err) begin
                if (rtry_q < RW'(MAX_RETRY)) begin
                    rtry_d  = rtry_q + 1'b1;
                    tot_d   = (tot_q == 4'hF) ? tot_q : tot_q + 1'b1;
                    state_d = ISSUE;
                end else begin
                    fault_d = 1'b1;
                    run_d   = 1'b0;
                    state_d = FAULT;
                end
            end else begin
                rtry_d = '0;
                stb_d  = (step_q == LAST_MSR);
                if (step_q == STOP_STEP) begin
                    state_d = IDLE;
                end else if (I_STOP) begin
                    run_d   = 1'b0;
                    step_d  = STOP_STEP;
                    state_d = HAS_FIFO ? ISSUE : IDLE;
                end else if (step_q == LAST_BRING) begin
                    run_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = WAIT_TICK;
                end else if (step_q == LAST_MSR) begin
                    state_d = WAIT_TICK;
                end else begin
                    step_d  = step_q + 3'd1;
                    state_d = ISSUE;
                end
            end
            WAIT_TICK: if (I_STOP) begin
                run_d   = 1'b0;
                rtry_d  = '0;
                step_d  = STOP_STEP;
                state_d = HAS_FIFO ? ISSUE : IDLE;
            end else if (tick) begin
                step_d  = FIRST_MSR;
                state_d = ISSUE;
            end
            FAULT: if (I_START) begin
                fault_d = 1'b0;
                step_d  = 3'd0;
                rtry_d  = '0;
                state_d = ISSUE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            step_q  <= '0;
            rtry_q  <= '0;
            tot_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            instr_q <= '0;
            err_q   <= 1'b0;
            run_q   <= 1'b0;
            stb_q   <= 1'b0;
            ovr_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            rtry_q  <= rtry_d;
            tot_q   <= tot_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            err_q   <= err_d;
            run_q   <= run_d;
            stb_q   <= stb_d;
            ovr_q   <= ovr_d;
            fault_q <= fault_d;
        end
    end

    assign O_EN        = (state_q == WAIT_ACC);
    assign O_INSTR     = instr_q;
    assign O_RUN       = run_q;
    assign O_SMP_STB   = stb_q;
    assign O_OVR       = ovr_q;
    assign O_FAULT     = fault_q;
    assign O_RETRY_CNT = tot_q;
endmodule

// File: tb/tb_mpu_6050_seq.sv
// tb_mpu_6050_seq: directed bench with a controller model and an instruction scoreboard.
module tb_mpu_6050_seq;
    localparam int ACC_TO = 16;

    logic       clk = 0, rst = 1, start = 0, stop = 0;
    logic       busy_m = 0, ack_m = 0;
    logic [7:0] rd_m = 0;
    logic       o_en, o_run, o_stb, o_ovr, o_fault;
    logic [7:0] o_instr;
    logic [3:0] o_retry;

    int         checks = 0, errors = 0;
    logic [7:0] exp_q[$];
    int         busy_len = 10, who_bad = 0, exp_retry = 0;
    logic       no_busy = 0, nack_en = 0;
    logic [7:0] nack_instr = 0;
    int         en_cnt = 0, last_len = 0;
    logic       en_prev = 0;

    mpu_6050_seq #(.FPGA_CLK(2000), .SAMPLE_HZ(10), .ACC_TO(ACC_TO)) dut (
        .CLK(clk), .RST(rst), .I_START(start), .I_STOP(stop), .I_BUSY(busy_m),
        .I_ACK_FL(ack_m), .I_RD_DATA(rd_m), .O_EN(o_en), .O_INSTR(o_instr), .O_RUN(o_run),
        .O_SMP_STB(o_stb), .O_OVR(o_ovr), .O_FAULT(o_fault), .O_RETRY_CNT(o_retry)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int w);
        case (w)
            0: sig = o_run;
            1: sig = o_fault;
            2: sig = o_stb;
            3: sig = o_en;
            default: sig = (o_instr == 8'h0A) && busy_m;
        endcase
    endfunction

    task automatic wait_for(input int w, input logic v, input int budget, input string tag);
        logic hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            hit = (sig(w) === v);
        end
        chk({"wait_", tag}, {7'd0, hit}, 8'd1);
    endtask

    task automatic pulse_start();
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    // controller model: answers each enable with a busy window
    initial begin
        logic [7:0] cur;
        forever begin
            @(negedge clk);
            if (o_en === 1'b1 && !no_busy) begin
                cur    = o_instr;
                busy_m = 1;
                repeat (busy_len) @(negedge clk);
                ack_m = nack_en && cur == nack_instr;
                rd_m  = (cur == 8'h0F) ? ((who_bad > 0) ? 8'h69 : 8'h68) : 8'h00;
                if (cur == 8'h0F && who_bad > 0) who_bad--;
                busy_m = 0;
                @(negedge clk);
                ack_m = 0;
            end
        end
    end

    // scoreboard: every enable rising edge pops one expected instruction
    initial begin
        forever begin
            @(negedge clk);
            if (o_en === 1'b1 && !en_prev) begin
                if (exp_q.size() == 0) chk("unexpected_issue", o_instr, 8'hXX);
                else chk("instr", o_instr, exp_q.pop_front());
            end
            if (o_en === 1'b1) en_cnt++;
            else if (en_prev) begin
                last_len = en_cnt;
                en_cnt   = 0;
            end
            en_prev = (o_en === 1'b1);
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_en", {7'd0, o_en}, 8'd0);
        chk("rst_instr", o_instr, 8'd0);
        chk("rst_run", {7'd0, o_run}, 8'd0);
        chk("rst_fault", {7'd0, o_fault}, 8'd0);
        chk("rst_ovr", {7'd0, o_ovr}, 8'd0);
        chk("rst_retry", {4'd0, o_retry}, 8'd0);
        rst = 0;
        @(negedge clk);
        // nominal bring-up and one measurement set
        exp_q.push_back(8'h0F); exp_q.push_back(8'h12);
        pulse_start();
        wait_for(0, 1, 200, "nom_run");
        chk("nom_retry", {4'd0, o_retry}, 8'd0);
        exp_q.push_back(8'h08); exp_q.push_back(8'h09); exp_q.push_back(8'h0A);
        wait_for(2, 1, 400, "nom_stb");
        @(negedge clk);
        chk("stb_one_cycle", {7'd0, o_stb}, 8'd0);
        chk("nom_run_hold", {7'd0, o_run}, 8'd1);
        chk("nom_sb_empty", 8'(exp_q.size()), 8'd0);
        // stop from WAIT_TICK, then WHO_AM_I mismatch once
        stop = 1;
        wait_for(0, 0, 10, "stop_idle");
        stop = 0;
        who_bad = 1;
        exp_retry = 1;
        exp_q.push_back(8'h0F); exp_q.push_back(8'h0F); exp_q.push_back(8'h12);
        pulse_start();
        wait_for(0, 1, 300, "who_run");
        chk("who_retry", {4'd0, o_retry}, 8'(exp_retry));
        exp_q.push_back(8'h08); exp_q.push_back(8'h09); exp_q.push_back(8'h0A);
        wait_for(2, 1, 400, "who_stb");
        // persistent NACK on TMP_MSR
        nack_en = 1; nack_instr = 8'h09;
        exp_q.push_back(8'h08);
        repeat (4) exp_q.push_back(8'h09);
        exp_retry += 3;
        wait_for(1, 1, 600, "nack_fault");
        chk("nack_en_low", {7'd0, o_en}, 8'd0);
        chk("nack_run_low", {7'd0, o_run}, 8'd0);
        chk("nack_retry", {4'd0, o_retry}, 8'(exp_retry));
        chk("nack_sb_empty", 8'(exp_q.size()), 8'd0);
        nack_en = 0;
        exp_q.push_back(8'h0F); exp_q.push_back(8'h12);
        pulse_start();
        chk("fault_cleared", {7'd0, o_fault}, 8'd0);
        wait_for(0, 1, 200, "restart_run");
        // stop while GYRO is busy: GYRO completes, then IDLE
        exp_q.push_back(8'h08); exp_q.push_back(8'h09); exp_q.push_back(8'h0A);
        wait_for(4, 1, 400, "gyro_busy");
        stop = 1;
        wait_for(0, 0, 40, "stop_after_gyro");
        chk("stop_busy_done", {7'd0, busy_m}, 8'd0);
        chk("stop_sb_empty", 8'(exp_q.size()), 8'd0);
        stop = 0;
        chk("no_ovr_yet", {7'd0, o_ovr}, 8'd0);
        // accept timeout on every attempt
        no_busy = 1;
        repeat (4) exp_q.push_back(8'h0F);
        exp_retry += 3;
        pulse_start();
        wait_for(1, 1, 300, "to_fault");
        chk("to_en_len", 8'(last_len), 8'(ACC_TO));
        chk("to_retry", {4'd0, o_retry}, 8'(exp_retry));
        chk("to_sb_empty", 8'(exp_q.size()), 8'd0);
        no_busy = 0;
        // overrun: set longer than the sample period
        busy_len = 80;
        exp_q.push_back(8'h0F); exp_q.push_back(8'h12);
        pulse_start();
        wait_for(0, 1, 400, "ovr_run");
        exp_q.push_back(8'h08); exp_q.push_back(8'h09); exp_q.push_back(8'h0A);
        wait_for(2, 1, 800, "ovr_stb");
        chk("ovr_set", {7'd0, o_ovr}, 8'd1);
        stop = 1;
        wait_for(0, 0, 10, "ovr_stop");
        stop = 0;
        repeat (3) @(negedge clk);
        chk("ovr_sticky", {7'd0, o_ovr}, 8'd1);
        // reset while waiting for accept
        busy_len = 10;
        no_busy = 1;
        exp_q.push_back(8'h0F);
        pulse_start();
        wait_for(3, 1, 10, "rst_en_up");
        rst = 1;
        @(posedge clk);
        #1;
        chk("rst2_en", {7'd0, o_en}, 8'd0);
        chk("rst2_instr", o_instr, 8'd0);
        chk("rst2_run", {7'd0, o_run}, 8'd0);
        chk("rst2_ovr", {7'd0, o_ovr}, 8'd0);
        chk("rst2_fault", {7'd0, o_fault}, 8'd0);
        chk("rst2_retry", {4'd0, o_retry}, 8'd0);
        chk("rst2_stb", {7'd0, o_stb}, 8'd0);
        chk("final_sb_empty", 8'(exp_q.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
